// File: rtl/fp_addsub_seq_ctrl_if.sv
// Operand/result handshake bundle for fp_addsub_seq_ctrl; master drives operands and
// takes results, slave is the arithmetic unit.
interface fp_addsub_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/fp_addsub_seq_ctrl.sv
// Multi-cycle IEEE754 single add/sub, truncating, one shared 25-bit adder; latency 1+align+1+norm+1,
// one operation in flight, result held in DONE until out_ready. FP_SPECIAL_EN adds inf/NaN bypass.
module fp_addsub_seq_ctrl #(
    parameter int ALIGN_STEP = 1,
    parameter int NORM_STEP  = 1
) (
    input logic                 clk,
    input logic                 rst,
    fp_addsub_seq_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_PACK  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]  state_q, state_d;
    logic        sign_q, sign_d;
    logic        sy_q, sy_d;
    logic [8:0]  exp_q, exp_d;
    logic [24:0] mx_q, mx_d;
    logic [23:0] my_q, my_d;
    logic [7:0]  rem_q, rem_d;
    logic [5:0]  tot_q, tot_d;
    logic [31:0] result_q, result_d;

    // Operand prep: flush denormals, apply op to B's sign, order by magnitude.
    logic        a_zero, b_zero, swap, sa, sb, sx_in, sy_in;
    logic [30:0] mag_a, mag_b, mag_x, mag_y;
    logic [23:0] mx_in, my_in;
    logic [7:0]  ed;

    assign a_zero = (bus.a[30:23] == 8'd0);
    assign b_zero = (bus.b[30:23] == 8'd0);
    assign mag_a  = a_zero ? 31'd0 : bus.a[30:0];
    assign mag_b  = b_zero ? 31'd0 : bus.b[30:0];
    assign sa     = bus.a[31];
    assign sb     = bus.b[31] ^ bus.op;
    assign swap   = (mag_b > mag_a);
    assign mag_x  = swap ? mag_b : mag_a;
    assign mag_y  = swap ? mag_a : mag_b;
    assign sx_in  = swap ? sb : sa;
    assign sy_in  = swap ? sa : sb;
    assign mx_in  = {|mag_x[30:23], mag_x[22:0]};
    assign my_in  = {|mag_y[30:23], mag_y[22:0]};
    assign ed     = mag_x[30:23] - mag_y[30:23];

`ifdef FP_SPECIAL_EN
    logic a_inf, b_inf, a_nan, b_nan;
    assign a_inf = (bus.a[30:23] == 8'hFF);
    assign b_inf = (bus.b[30:23] == 8'hFF);
    assign a_nan = a_inf && (bus.a[22:0] != 23'd0);
    assign b_nan = b_inf && (bus.b[22:0] != 23'd0);
`endif

    logic [7:0]  astep;
    assign astep = (rem_q < 8'(ALIGN_STEP)) ? rem_q : 8'(ALIGN_STEP);

    // The one mantissa adder: subtraction is add of the inverted operand plus carry-in.
    logic        eff_sub;
    logic [24:0] addend, sum;
    assign eff_sub = sign_q ^ sy_q;
    assign addend  = eff_sub ? ~{1'b0, my_q} : {1'b0, my_q};
    assign sum     = mx_q + addend + {24'd0, eff_sub};

    logic [2:0] nsh;
    always_comb begin
        nsh = 3'(NORM_STEP);
        for (int i = NORM_STEP - 1; i >= 0; i--) begin
            if (mx_q[23 - i]) nsh = 3'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        sy_d     = sy_q;
        exp_d    = exp_q;
        mx_d     = mx_q;
        my_d     = my_q;
        rem_d    = rem_q;
        tot_d    = tot_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = sx_in;
                    sy_d    = sy_in;
                    exp_d   = {1'b0, mag_x[30:23]};
                    mx_d    = {1'b0, mx_in};
                    my_d    = my_in;
                    rem_d   = ed;
                    tot_d   = 6'd0;
                    state_d = (ed == 8'd0) ? S_ADD : S_ALIGN;
`ifdef FP_SPECIAL_EN
                    if (a_inf || b_inf) begin
                        exp_d   = 9'd255;
                        state_d = S_PACK;
                        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
                            sign_d = 1'b0;
                            mx_d   = 25'h0400000;
                        end else begin
                            sign_d = a_inf ? sa : sb;
                            mx_d   = 25'd0;
                        end
                    end
`endif
                end
            end
            S_ALIGN: begin
                my_d  = my_q >> astep;
                rem_d = rem_q - astep;
                tot_d = tot_q + 6'(astep);
                if (rem_d == 8'd0 || tot_d >= 6'd25) state_d = S_ADD;
            end
            S_ADD: begin
                mx_d    = sum;
                state_d = S_NORM;
            end
            S_NORM: begin
                if (mx_q[24]) begin
                    state_d = S_PACK;
                    if (exp_q + 9'd1 >= 9'd255) begin
                        exp_d = 9'd255;
                        mx_d  = 25'd0;
                    end else begin
                        exp_d = exp_q + 9'd1;
                        mx_d  = mx_q >> 1;
                    end
                end else if (mx_q == 25'd0) begin
                    sign_d  = 1'b0;
                    exp_d   = 9'd0;
                    state_d = S_PACK;
                end else if (mx_q[23]) begin
                    state_d = S_PACK;
                end else if (exp_q <= {6'd0, nsh}) begin
                    exp_d   = 9'd0;
                    mx_d    = 25'd0;
                    state_d = S_PACK;
                end else begin
                    mx_d  = mx_q << nsh;
                    exp_d = exp_q - {6'd0, nsh};
                end
            end
            S_PACK: begin
                result_d = {sign_q, exp_q[7:0], mx_q[22:0]};
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            sy_q     <= 1'b0;
            exp_q    <= 9'd0;
            mx_q     <= 25'd0;
            my_q     <= 24'd0;
            rem_q    <= 8'd0;
            tot_q    <= 6'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            sy_q     <= sy_d;
            exp_q    <= exp_d;
            mx_q     <= mx_d;
            my_q     <= my_d;
            rem_q    <= rem_d;
            tot_q    <= tot_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.result    = result_q;
endmodule

// File: tb/tb_fp_addsub_seq_ctrl.sv
// Directed-vector bench for fp_addsub_seq_ctrl with ALIGN_STEP=1, NORM_STEP=1.
module tb_fp_addsub_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;

    fp_addsub_seq_ctrl_if bif();

    fp_addsub_seq_ctrl #(.ALIGN_STEP(1), .NORM_STEP(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic opv,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        bif.a        = av;
        bif.b        = bv;
        bif.op       = opv;
        bif.in_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            bif.in_valid = 1'b0;
            lat++;
        end while (!bif.out_valid && lat < 200);
        if (!bif.out_valid) chk("timeout", {31'd0, bif.out_valid}, 32'd1);
        res = bif.result;
        bif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bif.out_ready = 1'b0;
    endtask

    task automatic vec(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic opv, input logic [31:0] exp_res, input int exp_lat);
        logic [31:0] res;
        int          lat;
        run_op(av, bv, opv, res, lat);
        chk({tag, "_res"}, res, exp_res);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        logic [31:0] r0;
        int          n;
        rst           = 1'b1;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b0;
        bif.a         = 32'd0;
        bif.b         = 32'd0;
        bif.op        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, bif.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bif.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, bif.busy}, 32'd0);
        chk("rst_result", bif.result, 32'd0);

        vec("one_plus_one",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4);
        vec("three_minus_one",32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 5);
        vec("cancel",         32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4);
        vec("align_cap",      32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 29);
        vec("mixed_signs",    32'h3FC00000, 32'hBF000000, 1'b0, 32'h3F800000, 5);
        vec("norm_shift2",    32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 7);
        vec("swap_neg",       32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 5);
        vec("denorm_plus_1",  32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 29);
        vec("denorm_pair",    32'h00400000, 32'h00400000, 1'b0, 32'h00000000, 4);
        vec("overflow_inf",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4);
        vec("underflow_neg",  32'h80C00000, 32'h80800000, 1'b1, 32'h80000000, 4);
        vec("truncate",       32'h3F800000, 32'h34400000, 1'b0, 32'h3F800001, 27);
`ifdef FP_SPECIAL_EN
        vec("inf_minus_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 2);
        vec("inf_plus_one",   32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 2);
        vec("nan_in",         32'h3F800000, 32'h7F800001, 1'b0, 32'h7FC00000, 2);
`endif

        // Result held in DONE while the consumer stalls; new offers are ignored.
        @(negedge clk);
        bif.a        = 32'h3F800000;
        bif.b        = 32'h3F800000;
        bif.op       = 1'b0;
        bif.in_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            bif.in_valid = 1'b0;
            n++;
        end while (!bif.out_valid && n < 200);
        chk("stall_reach_done", {31'd0, bif.out_valid}, 32'd1);
        r0 = bif.result;
        chk("stall_first_res", r0, 32'h40000000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bif.a        = 32'h40400000;
            bif.in_valid = (i % 2 == 0);
            @(posedge clk);
            #1;
            chk("stall_out_valid", {31'd0, bif.out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, bif.in_ready}, 32'd0);
            chk("stall_result", bif.result, 32'h40000000);
        end
        @(negedge clk);
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bif.out_ready = 1'b0;
        chk("release_in_ready", {31'd0, bif.in_ready}, 32'd1);
        chk("release_out_valid", {31'd0, bif.out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("ignored_offer_busy", {31'd0, bif.busy}, 32'd0);

        // Reset in the middle of a long alignment.
        @(negedge clk);
        bif.a        = 32'h3F800000;
        bif.b        = 32'h30800000;
        bif.op       = 1'b0;
        bif.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("align_busy", {31'd0, bif.busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", {31'd0, bif.busy}, 32'd0);
        chk("midrst_in_ready", {31'd0, bif.in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, bif.out_valid}, 32'd0);
        chk("midrst_result", bif.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        vec("after_rst", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_addsub_seq_ctrl.md
FP_ADDSUB_SEQ_CTRL -- requirements
Module: fp_addsub_seq_ctrl

Interface
REQ-001 SHALL have parameter ALIGN_STEP, default 1, mantissa bits shifted right per ALIGN cycle (legal: 1, 2, 4, 8).
REQ-002 SHALL have parameter NORM_STEP, default 1, mantissa bits shifted left per NORM cycle (legal: 1, 2, 4).
REQ-003 SHALL have one clock and synchronous active-high reset: clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  operand pair offered.
REQ-006 in_ready  out  1  block can accept operands.
REQ-007 a  in  32  IEEE754 single operand A.
REQ-008 b  in  32  IEEE754 single operand B.
REQ-009 op  in  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  consumer takes result.
REQ-012 result  out  32  IEEE754 single result.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 SHALL use an FSM with states IDLE, ALIGN, ADD, NORM, PACK, DONE, and a single shared 25-bit adder for all mantissa add/subtract work.
REQ-015 IDLE: in_ready=1; on in_valid&in_ready, latch operands, apply op by inverting B's sign, and swap so |X|>=|Y| (compare exponent, then mantissa); exp_diff = eX-eY; go to ALIGN.
REQ-016 Denormal inputs (exp=0) SHALL be flushed to signed zero before the swap.
REQ-017 ALIGN: shift mY right by min(ALIGN_STEP, remaining) per cycle; when the remaining count reaches 0 or total shift reaches 25, go to ADD (0 cycles in ALIGN when exp_diff=0).
REQ-018 ADD: one cycle; same effective sign -> mX+mY (25-bit, carry kept); otherwise mX+two's complement(mY).
REQ-019 NORM: if carry set, shift right 1 and increment exponent in one cycle, then go to PACK; if sum==0, force +0 and go to PACK; otherwise shift left by up to NORM_STEP per cycle, decrementing exponent, until bit23 is set.
REQ-020 When the exponent would reach 0 during a left shift, NORM SHALL flush to signed zero; when it reaches 255 after a carry, the result SHALL be signed infinity.
REQ-021 Rounding SHALL be truncation (round toward zero); shifted-out bits are discarded.
REQ-022 PACK: one cycle; assemble {sign, exp[7:0], mant[22:0]} into result register; go to DONE.
REQ-023 DONE: out_valid=1, result stable; on out_ready go to IDLE (in_ready rises the next cycle; no same-cycle accept).
REQ-024 Exact cancellation (|A|=|B|, opposite effective signs) SHALL yield +0 (0x00000000).
REQ-025 Latency from accept to out_valid SHALL be 1 + ceil(min(exp_diff,25)/ALIGN_STEP) + 1 + NORM cycles + 1 cycles.
REQ-026 in_valid asserted while busy SHALL be ignored; operands are not re-sampled.

Reset
REQ-027 rst SHALL force IDLE on the next clk edge from any state, abandoning any operation in flight.
REQ-028 Reset values: in_ready=1 (first cycle after reset), out_valid=0, busy=0, result=0x00000000; all internal registers 0.

Configuration
REQ-029 Macro FP_SPECIAL_EN: when defined, an exp=255 operand in IDLE SHALL bypass ALIGN/ADD/NORM and go to PACK: NaN in -> 0x7FC00000; inf-inf (effective) -> 0x7FC00000; otherwise inf of its sign.
REQ-030 Without FP_SPECIAL_EN, exp=255 SHALL be processed as an ordinary exponent, with no special-case logic present.

Verification
REQ-031 a=0x3F800000, b=0x3F800000, op=0 -> result 0x40000000; latency 4 cycles with ALIGN_STEP=1.
REQ-032 a=0x40400000, b=0x3F800000, op=1 -> 0x40000000; a=0x3F800000, b=0x3F800000, op=1 -> 0x00000000.
REQ-033 a=0x3F800000, b=0x30800000, op=0 -> 0x3F800000; ALIGN stops at a 25-bit shift (25 cycles with step 1).
REQ-034 With FP_SPECIAL_EN: a=0x7F800000, b=0x7F800000, op=1 -> 0x7FC00000; a=0x7F800000, b=0x3F800000 -> 0x7F800000.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> out_valid and result stable, in_ready=0; in_valid pulses are ignored.
REQ-036 Assert rst during ALIGN -> next cycle IDLE, out_valid=0, result=0; a subsequent 0x3F800000+0x3F800000 returns 0x40000000.
